// File: rtl/maze_lookup_arbiter.sv
// Round-robin arbiter that funnels mover legal-move lookups into one maze memory port.
// Define PACMAN_PRIORITY_EN to let mover 0 (pacman) win whenever it requests.
module maze_lookup_arbiter #(
    parameter int NREQ    = 5,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*10-1:0]   req_x,
    input  logic [NREQ*10-1:0]   req_y,
    input  logic                 hold,
    output logic [NREQ-1:0]      gnt,
    output logic                 mem_rd,
    output logic [9:0]           mem_x,
    output logic [9:0]           mem_y,
    input  logic [3:0]           mem_legal,
    output logic                 rsp_valid,
    output logic [2:0]           rsp_id,
    output logic [3:0]           rsp_legal
);

    localparam logic [9:0] XY_LIMIT = 10'd480;

    logic [2:0]          rr_ptr_reg, rr_ptr_next;
    logic [NREQ-1:0]     scan_req;
    logic                win_found;
    logic [2:0]          win_idx;
    logic [2:0]          win_idx_inc;
    logic                grant_ok;
    logic [9:0]          win_x, win_y;
    logic                win_oor;
    int                  scan_idx;

    logic [NREQ-1:0]     gnt_reg;
    logic                mem_rd_reg;
    logic [9:0]          mem_x_reg, mem_y_reg;
    logic                issue_valid_reg;
    logic [2:0]          issue_id_reg;
    logic                issue_oor_reg;

    logic [MEM_LAT-1:0]   tag_valid_reg, tag_valid_next;
    logic [MEM_LAT-1:0]   tag_oor_reg, tag_oor_next;
    logic [3*MEM_LAT-1:0] tag_id_reg, tag_id_next;

    logic                rsp_valid_reg;
    logic [2:0]          rsp_id_reg;
    logic [3:0]          rsp_legal_reg;

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        scan_req  = req;
        win_found = 1'b0;
        win_idx   = 3'd0;
        scan_idx  = 0;
`ifdef PACMAN_PRIORITY_EN
        scan_req[0] = 1'b0;
`endif
        for (int off = NREQ - 1; off >= 0; off--) begin
            scan_idx = (int'(rr_ptr_reg) + off) % NREQ;
            if (scan_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = 3'(scan_idx);
            end
        end
`ifdef PACMAN_PRIORITY_EN
        if (req[0]) begin
            win_found = 1'b1;
            win_idx   = 3'd0;
        end
`endif
        grant_ok = win_found && !hold;
    end

    always_comb begin
        win_x       = req_x[int'(win_idx)*10 +: 10];
        win_y       = req_y[int'(win_idx)*10 +: 10];
        win_oor     = (win_x >= XY_LIMIT) || (win_y >= XY_LIMIT);
        win_idx_inc = (int'(win_idx) == NREQ - 1) ? 3'd0 : win_idx + 3'd1;
        rr_ptr_next = rr_ptr_reg;
        if (grant_ok) begin
`ifdef PACMAN_PRIORITY_EN
            // Pacman grants bypass the ghosts' rotation entirely.
            if (win_idx != 3'd0) begin
                rr_ptr_next = win_idx_inc;
            end
`else
            rr_ptr_next = win_idx_inc;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg      <= 3'd0;
            gnt_reg         <= '0;
            mem_rd_reg      <= 1'b0;
            mem_x_reg       <= 10'd0;
            mem_y_reg       <= 10'd0;
            issue_valid_reg <= 1'b0;
            issue_id_reg    <= 3'd0;
            issue_oor_reg   <= 1'b0;
        end else begin
            rr_ptr_reg      <= rr_ptr_next;
            gnt_reg         <= grant_ok ? (NREQ'(1) << win_idx) : '0;
            mem_rd_reg      <= grant_ok && !win_oor;
            issue_valid_reg <= grant_ok;
            if (grant_ok) begin
                mem_x_reg     <= win_x;
                mem_y_reg     <= win_y;
                issue_id_reg  <= win_idx;
                issue_oor_reg <= win_oor;
            end
        end
    end

    // Tag slot MEM_LAT-1 lines up with the cycle mem_legal is valid for that read.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_next[0]  = issue_valid_reg;
                assign tag_oor_next[0]    = issue_oor_reg;
                assign tag_id_next[2:0]   = issue_id_reg;
            end else begin : g_shift
                assign tag_valid_next[gi]      = tag_valid_reg[gi-1];
                assign tag_oor_next[gi]        = tag_oor_reg[gi-1];
                assign tag_id_next[3*gi +: 3]  = tag_id_reg[3*(gi-1) +: 3];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_reg <= '0;
            tag_oor_reg   <= '0;
            tag_id_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 3'd0;
            rsp_legal_reg <= 4'd0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_oor_reg   <= tag_oor_next;
            tag_id_reg    <= tag_id_next;
            rsp_valid_reg <= tag_valid_reg[MEM_LAT-1];
            if (tag_valid_reg[MEM_LAT-1]) begin
                rsp_id_reg    <= tag_id_reg[3*(MEM_LAT-1) +: 3];
                rsp_legal_reg <= tag_oor_reg[MEM_LAT-1] ? 4'd0 : mem_legal;
            end
        end
    end

    assign gnt       = gnt_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_x     = mem_x_reg;
    assign mem_y     = mem_y_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_legal = rsp_legal_reg;

endmodule

// File: tb/tb_maze_lookup_arbiter.sv
// Bench for maze_lookup_arbiter: directed vector table, corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_maze_lookup_arbiter;

    localparam int NREQ    = 5;
    localparam int MEM_LAT = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*10-1:0]   req_x, req_y;
    logic                 hold;
    logic [NREQ-1:0]      gnt;
    logic                 mem_rd;
    logic [9:0]           mem_x, mem_y;
    logic [3:0]           mem_legal;
    logic                 rsp_valid;
    logic [2:0]           rsp_id;
    logic [3:0]           rsp_legal;

    always #5 clk = ~clk;

    maze_lookup_arbiter #(.NREQ(NREQ), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y), .hold(hold),
        .gnt(gnt), .mem_rd(mem_rd), .mem_x(mem_x), .mem_y(mem_y), .mem_legal(mem_legal),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_legal(rsp_legal)
    );

    function automatic logic [3:0] legal_of(logic [9:0] x, logic [9:0] y);
        return x[3:0] ^ y[7:4] ^ 4'hA;
    endfunction

    // Maze memory: answers MEM_LAT cycles after a strobe, noise otherwise.
    logic [3:0] mem_pipe [MEM_LAT];
    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
        mem_pipe[0] <= mem_rd ? legal_of(mem_x, mem_y) : 4'($urandom);
    end
    assign mem_legal = mem_pipe[MEM_LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rr = 0;

    typedef struct {
        int         due;
        int         id;
        logic [3:0] legal;
    } rsp_t;
    rsp_t rq[$];

    logic [NREQ-1:0] exp_gnt;
    logic            exp_rd;
    logic [9:0]      exp_x, exp_y;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(logic [NREQ-1:0] r);
`ifdef PACMAN_PRIORITY_EN
        if (r[0]) return 0;
        r[0] = 1'b0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_all_xy(int x, int y);
        for (int i = 0; i < NREQ; i++) begin
            req_x[10*i +: 10] = 10'(x);
            req_y[10*i +: 10] = 10'(y);
        end
    endtask

    // Apply current inputs for one cycle, then compare the cycle that follows.
    task automatic step();
        int         w;
        logic [9:0] x, y;
        logic       oor;
        w       = -1;
        exp_gnt = '0;
        exp_rd  = 1'b0;
        if (!hold && req != '0) w = pick(req);
        if (w >= 0) begin
            exp_gnt[w] = 1'b1;
            x   = req_x[10*w +: 10];
            y   = req_y[10*w +: 10];
            oor = (x >= 10'd480) || (y >= 10'd480);
            exp_rd = !oor;
            exp_x  = x;
            exp_y  = y;
            rq.push_back('{cyc + MEM_LAT + 2, w, oor ? 4'd0 : legal_of(x, y)});
`ifdef PACMAN_PRIORITY_EN
            if (w != 0) rr = (w + 1) % NREQ;
`else
            rr = (w + 1) % NREQ;
`endif
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (gnt != '0 || rsp_valid)
            $display("cyc %0d gnt=%b mem_rd=%b x=%0d y=%0d rsp_valid=%b rsp_id=%0d rsp_legal=%b",
                     cyc, gnt, mem_rd, mem_x, mem_y, rsp_valid, rsp_id, rsp_legal);
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
        if (exp_rd) begin
            chk("mem_x", 32'(mem_x), 32'(exp_x));
            chk("mem_y", 32'(mem_y), 32'(exp_y));
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(rq[0].id));
            chk("rsp_legal", 32'(rsp_legal), 32'(rq[0].legal));
            void'(rq.pop_front());
        end else begin
            chk("rsp_idle", 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_xy", {12'd0, mem_x, mem_y}, 32'd0);
        chk("rst_rsp", {24'd0, rsp_valid, rsp_id, rsp_legal}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        rq.delete();
        rr = 0;
        @(negedge clk);
        rst  = 1'b0;
        req  = '0;
        hold = 1'b0;
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        int              x;
        int              y;
        logic [NREQ-1:0] gnt;
        logic            rd;
        int              id;
    } vec_t;
    vec_t tbl[7];

    initial begin
        logic [NREQ-1:0] got [10];
        int              n_gnt, n_rsp;

        tbl[0] = '{5'b00100, 100, 200, 5'b00100, 1'b1, 2};
        tbl[1] = '{5'b00010, 480, 5, 5'b00010, 1'b0, 1};
        tbl[2] = '{5'b00010, 5, 480, 5'b00010, 1'b0, 1};
        tbl[3] = '{5'b10000, 479, 479, 5'b10000, 1'b1, 4};
        tbl[4] = '{5'b11000, 0, 0, 5'b01000, 1'b1, 3};
        tbl[5] = '{5'b00001, 1023, 0, 5'b00001, 1'b0, 0};
        tbl[6] = '{5'b01010, 300, 300, 5'b00010, 1'b1, 1};

        rst   = 1'b1;
        req   = '0;
        hold  = 1'b0;
        req_x = '0;
        req_y = '0;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Directed single lookups from a fresh reset.
        for (int t = 0; t < 7; t++) begin
            do_reset();
            set_all_xy(tbl[t].x, tbl[t].y);
            req = tbl[t].req;
            step();
            chk("tbl_gnt", 32'(gnt), 32'(tbl[t].gnt));
            chk("tbl_rd", 32'(mem_rd), 32'(tbl[t].rd));
            req = '0;
            for (int k = 0; k < MEM_LAT + 1; k++) step();
            chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("tbl_rsp_id", 32'(rsp_id), 32'(tbl[t].id));
            chk("tbl_rsp_legal", 32'(rsp_legal),
                32'(tbl[t].rd ? legal_of(10'(tbl[t].x), 10'(tbl[t].y)) : 4'd0));
        end

        // Everyone requesting, then pacman drops out.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_x[10*i +: 10] = 10'(40 * i + 7);
            req_y[10*i +: 10] = 10'(33 * i + 90);
        end
        req = '1;
        for (int k = 0; k < 6; k++) begin
            step();
            got[k] = gnt;
        end
        req = 5'b11110;
        for (int k = 6; k < 10; k++) begin
            step();
            got[k] = gnt;
        end
        for (int k = 0; k < 6; k++) begin
`ifdef PACMAN_PRIORITY_EN
            chk("allreq_order", 32'(got[k]), 32'd1);
`else
            chk("allreq_order", 32'(got[k]), 32'(1 << (k % NREQ)));
`endif
        end
        for (int k = 6; k < 10; k++) chk("ghost_order", 32'(got[k]), 32'(1 << (k - 5)));
        req = '0;
        for (int k = 0; k < MEM_LAT + 2; k++) step();

        // Hold after two grants: pending lookups still answer.
        do_reset();
        set_all_xy(17, 250);
        req = 5'b00110;
        step();
        step();
        hold  = 1'b1;
        n_gnt = 0;
        n_rsp = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (gnt != '0) n_gnt++;
            if (rsp_valid) n_rsp++;
        end
        chk("hold_gnt_count", 32'(n_gnt), 32'd0);
        chk("hold_rsp_count", 32'(n_rsp), 32'd2);
        hold = 1'b0;
        req  = '0;
        step();

        // Reset with two lookups in flight.
        do_reset();
        set_all_xy(60, 61);
        req = 5'b00011;
        step();
        step();
        do_reset();
        n_rsp = 0;
        for (int k = 0; k < MEM_LAT + 3; k++) begin
            step();
            if (rsp_valid) n_rsp++;
        end
        chk("flushed_rsp_count", 32'(n_rsp), 32'd0);
        req = 5'b11010;
        step();
        chk("post_rst_first_gnt", 32'(gnt), 32'b00010);
        req = '0;
        for (int k = 0; k < MEM_LAT + 2; k++) step();

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            req  = NREQ'($urandom);
            hold = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < NREQ; i++) begin
                req_x[10*i +: 10] = 10'($urandom_range(0, 520));
                req_y[10*i +: 10] = 10'($urandom_range(0, 520));
            end
            step();
        end
        req  = '0;
        hold = 1'b0;
        for (int k = 0; k < MEM_LAT + 2; k++) step();
        chk("model_queue_drained", 32'(rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maze_lookup_arbiter.md
MAZE_LOOKUP_ARBITER -- requirements
Module: maze_lookup_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 5, number of movers (index 0 = pacman, 1..4 = ghosts).
REQ-002 The block SHALL have parameter MEM_LAT, default 2, fixed maze-memory read latency in clk cycles (legal range 1..4).
REQ-003 clk  input  1  system clock; all state on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-mover lookup request, level, held until granted.
REQ-006 req_x  input  NREQ*10  packed maze-relative x per mover, mover i in bits [10i+9:10i].
REQ-007 req_y  input  NREQ*10  packed maze-relative y per mover, same packing.
REQ-008 hold  input  1  when high, no new grants are issued.
REQ-009 gnt  output  NREQ  one-hot grant pulse, registered.
REQ-010 mem_rd  output  1  maze-memory read strobe, registered.
REQ-011 mem_x, mem_y  output  10 each  maze-memory read address, registered.
REQ-012 mem_legal  input  4  {up,down,left,right} legal-move bits, valid exactly MEM_LAT cycles after mem_rd.
REQ-013 rsp_valid  output  1  response strobe.
REQ-014 rsp_id  output  3  index of mover the response belongs to.
REQ-015 rsp_legal  output  4  legal-move nibble {up,down,left,right}.

Function
REQ-016 Arbitration SHALL evaluate each cycle with hold low: winner = first asserted req at or after rr_ptr, wrapping NREQ-1 -> 0.
REQ-017 At most one gnt bit SHALL be high per cycle; gnt is a one-cycle pulse in the cycle after the winning req is sampled.
REQ-018 After a grant to mover k, rr_ptr SHALL become (k+1) mod NREQ; with no grant, rr_ptr holds.
REQ-019 A mover whose req is still high the cycle after its gnt SHALL be treated as a new request.
REQ-020 mem_rd, mem_x, mem_y SHALL be asserted in the same cycle as gnt, carrying the granted mover's coordinates sampled on the arbitration edge.
REQ-021 Coordinates with x>=480 or y>=480 SHALL still be granted, but mem_rd SHALL stay low and the response SHALL carry rsp_legal=4'b0000.
REQ-022 A tag pipeline of depth MEM_LAT SHALL carry {valid, id, out_of_range} per slot, one slot issued per cycle.
REQ-023 rsp_valid SHALL rise exactly MEM_LAT+1 cycles after the corresponding gnt, with rsp_id = granted index and rsp_legal = registered mem_legal (or 0 per REQ-021).
REQ-024 Throughput SHALL be one grant and one response per cycle sustained, with responses in grant order.
REQ-025 hold high SHALL block new grants only; in-flight tags SHALL drain and respond normally.
REQ-026 req=0 or hold=1: gnt=0, mem_rd=0, no tag issued.

Reset
REQ-027 On rst: gnt=0, mem_rd=0, mem_x=0, mem_y=0, rsp_valid=0, rsp_id=0, rsp_legal=0, rr_ptr=0, all tag slots invalid.
REQ-028 Reset mid-operation SHALL discard in-flight lookups; no rsp_valid for them after rst deasserts.

Configuration
REQ-029 Macro PACMAN_PRIORITY_EN defined: req[0] SHALL win whenever asserted, round-robin applies among 1..NREQ-1, and a grant to 0 SHALL NOT change rr_ptr.
REQ-030 Macro PACMAN_PRIORITY_EN undefined: all NREQ movers SHALL share pure round-robin per REQ-016..018.

Verification
REQ-031 Single request: req=5'b00100, x=100, y=200, MEM_LAT=2 -> gnt=5'b00100 and mem_rd with mem_x=100, mem_y=200 one cycle later; rsp_valid, rsp_id=2 three cycles after gnt.
REQ-032 All five req held high, macro undefined -> grants 0,1,2,3,4,0 on consecutive cycles; responses in same order.
REQ-033 All req held high, PACMAN_PRIORITY_EN defined -> gnt[0] every cycle; ghosts starve; drop req[0] -> grants 1,2,3,4 in order.
REQ-034 req[1] with x=480 -> gnt[1], mem_rd=0, rsp_valid with rsp_id=1, rsp_legal=4'b0000 at MEM_LAT+1.
REQ-035 hold raised one cycle after two grants -> no further gnt while hold=1; both pending responses still delivered.
REQ-036 rst pulsed with two lookups in flight -> all outputs 0 immediately; no rsp_valid afterwards until new grant; first grant goes to lowest requesting index.
